apb_master: RTL
===============

Name: apb_master

Overview:
- APB3-style bus master that turns a simple CPU-side request into APB SETUP/ACCESS transfers.
- Decodes the address into one of NUM_SLV slave selects and muxes the selected slave's PRDATA/PREADY back.
- Sits directly upstream of the GPO/GPI/UART peripherals; the top level slices PADDR to each slave's local width.

Parameters:
- NUM_SLV, 4, number of slave regions/PSEL lines.
- BASE_ADDR, 32'h1000_0000, start of the peripheral address window.
- SLV_SPAN, 12, log2 of the byte size of each slave region (4 KB).
- TIMEOUT, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  bus clock; all logic on the rising edge.
- PRESET  input  1  asynchronous, active-low reset.
- transfer  input  1  request strobe; sampled only in IDLE.
- write  input  1  1=write, 0=read; sampled with transfer.
- addr  input  32  byte address; sampled with transfer.
- wdata  input  32  write data; sampled with transfer.
- rdata  output  32  read data; valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- err  output  1  completion-with-error flag; qualified by ready.
- busy  output  1  high from request accept until completion.
- PADDR  output  32  full latched address.
- PWRITE  output  1  latched direction.
- PENABLE  output  1  ACCESS-phase indicator.
- PWDATA  output  32  latched write data.
- PSEL  output  NUM_SLV  one-hot slave select.
- PRDATA  input  NUM_SLV*32  concatenated slave read buses; slave i is at [32*i +: 32].
- PREADY  input  NUM_SLV  per-slave ready.

Behaviour:
- Reset (PRESET=0, asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, busy=0.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - On transfer=1, latch addr/write/wdata into PADDR/PWRITE/PWDATA and set busy=1.
  - Decode hit: slave index = (addr-BASE_ADDR)>>SLV_SPAN. Hit if BASE_ADDR <= addr < BASE_ADDR+(NUM_SLV<<SLV_SPAN). Go to SETUP and set PSEL[index]=1, PENABLE=0.
  - Decode miss: no APB cycle, PSEL stays 0. Next cycle ready=1, err=1, rdata=0, busy=0; stay in IDLE.
- SETUP: exactly one cycle, then ACCESS with PENABLE=1. PADDR/PWRITE/PWDATA/PSEL held stable.
- ACCESS:
  - Hold all APB outputs until the selected PREADY is sampled 1. Only PREADY[index] matters; other slaves' PREADY and PRDATA are ignored.
  - On that edge, go to IDLE with PSEL=0, PENABLE=0, ready=1, err=0, busy=0.
  - rdata = selected PRDATA on a read; rdata is left unchanged on a write.
- Latency with a zero-wait-state slave: transfer sampled at edge k, SETUP at k+1, ACCESS at k+2, ready at k+3. Each slave wait state adds one cycle.
- A registered-PREADY slave (PREADY rises one cycle after PSEL&&PENABLE) completes with ready at k+4.
- transfer during SETUP/ACCESS is ignored, not queued. A transfer held high continuously starts a new request in the IDLE cycle that carries ready, so back-to-back issue is possible.
- PADDR, PWDATA and PWRITE keep their last value in IDLE.
- Address arithmetic is unsigned 32-bit. The region upper bound is computed in 33 bits so it cannot wrap.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with PREADY low.
  - When it reaches TIMEOUT, abort: PSEL=0, PENABLE=0, go to IDLE, ready=1, err=1, rdata=0.
  - A PREADY arriving on the same edge as the limit wins: normal completion, err=0.
- Undefined: no counter exists; ACCESS waits indefinitely, and err comes only from decode miss.

Decomposition:
- Package apb_pkg:
  - ADDR_W=32, DATA_W=32.
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e.
  - Default BASE_ADDR/SLV_SPAN/NUM_SLV constants.
- Sub-module apb_addr_decoder (combinational):
  - addr -> one-hot sel, index, hit.
  - index -> muxed PRDATA/PREADY.
- The FSM and registers stay in apb_master.

Test Plan:
- Write 0x0000_00A5 to 0x1000_0004; slave 0 returns PREADY one cycle after PSEL&&PENABLE -> PSEL=4'b0001 for 3 cycles, PENABLE high on the last 2, ready at k+4, err=0, slave sees PWDATA=0xA5.
- Read 0x1000_1000; slave 1 PRDATA=0x1234_5678 with zero wait states -> PSEL=4'b0010, ready at k+3, rdata=0x1234_5678, err=0.
- Access 0x1000_4000 (first byte past the window) and 0x0FFF_FFFC -> PSEL never asserts, ready+err one cycle after accept, rdata=0.
- transfer held high for two writes to slaves 2 and 3 -> second SETUP begins the cycle after the first ready; no overlapping PSEL bits.
- PRESET pulsed low during ACCESS -> PSEL/PENABLE/busy drop to 0 immediately, no ready pulse; the next request completes normally.
- With APB_TIMEOUT_EN and TIMEOUT=16, slave never ready -> abort after 16 ACCESS cycles with ready=1, err=1, PSEL=0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared widths, default address map and FSM state type for the
// APB master and its address decoder.
package apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Default peripheral map: 4 slaves of 4 KB each starting at 0x1000_0000.
  localparam int                DEF_NUM_SLV   = 4;
  localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam int                DEF_SLV_SPAN  = 12;
  localparam int                DEF_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Width of a slave index; a single-slave build still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: purely combinational. Maps a byte address onto one of
// NUM_SLV equally sized regions (one-hot select, binary index, hit flag) and
// returns the PRDATA/PREADY of the slave named by rd_index.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLV   = DEF_NUM_SLV,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                SLV_SPAN  = DEF_SLV_SPAN,
  localparam int               IDX_W     = idx_width(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]         addr,
  output logic [NUM_SLV-1:0]        sel,
  output logic [IDX_W-1:0]          index,
  output logic                      hit,
  input  logic [IDX_W-1:0]          rd_index,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  output logic [DATA_W-1:0]         prdata_sel,
  output logic                      pready_sel
);

  // Window bounds are kept in ADDR_W+1 bits so the upper bound of a window
  // that ends exactly at 4 GB does not wrap to zero.
  localparam logic [ADDR_W:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI_BOUND = {1'b0, BASE_ADDR} +
                                         ((ADDR_W+1)'(NUM_SLV) << SLV_SPAN);

  logic [ADDR_W-1:0] offset;

  assign offset = addr - BASE_ADDR;
  assign hit    = ({1'b0, addr} >= LO_BOUND) && ({1'b0, addr} < HI_BOUND);
  assign index  = IDX_W'(offset >> SLV_SPAN);

  // One select line per region; all lines stay low on a miss.
  genvar gi;
  for (gi = 0; gi < NUM_SLV; gi++) begin : g_sel
    assign sel[gi] = hit && (index == IDX_W'(gi));
  end

  // Return path: only the slave named by rd_index is looked at.
  always_comb begin
    prdata_sel = '0;
    pready_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (rd_index == IDX_W'(i)) begin
        prdata_sel = PRDATA[DATA_W*i +: DATA_W];
        pready_sel = PREADY[i];
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// apb_master: turns a single-cycle CPU request (transfer/write/addr/wdata)
// into an APB3 SETUP/ACCESS transfer and reports completion on ready/err.
// All outputs are registered. Requests outside the peripheral window complete
// one cycle later with err=1 and no bus activity.
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase that waits
// TIMEOUT cycles without PREADY, completing with err=1.
module apb_master
  import apb_pkg::*;
#(
  parameter int                NUM_SLV   = DEF_NUM_SLV,
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int                SLV_SPAN  = DEF_SLV_SPAN,
  parameter int                TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      transfer,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [DATA_W-1:0]         PWDATA,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY
);

  localparam int IDX_W = idx_width(NUM_SLV);

  apb_state_e state_reg, state_next;

  logic [ADDR_W-1:0]  paddr_reg,   paddr_next;
  logic               pwrite_reg,  pwrite_next;
  logic [DATA_W-1:0]  pwdata_reg,  pwdata_next;
  logic               penable_reg, penable_next;
  logic [NUM_SLV-1:0] psel_reg,    psel_next;
  logic [DATA_W-1:0]  rdata_reg,   rdata_next;
  logic               ready_reg,   ready_next;
  logic               err_reg,     err_next;
  logic               busy_reg,    busy_next;
  logic [IDX_W-1:0]   slv_idx_reg, slv_idx_next;

  logic [NUM_SLV-1:0] dec_sel;
  logic [IDX_W-1:0]   dec_index;
  logic               dec_hit;
  logic [DATA_W-1:0]  sel_prdata;
  logic               sel_pready;
  logic               tmo_hit;

  // Decode the live request address; the return mux follows the index
  // latched at accept time so a changing addr input cannot disturb it.
  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SPAN  (SLV_SPAN)
  ) u_dec (
    .addr       (addr),
    .sel        (dec_sel),
    .index      (dec_index),
    .hit        (dec_hit),
    .rd_index   (slv_idx_reg),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .prdata_sel (sel_prdata),
    .pready_sel (sel_pready)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;

  // Count ACCESS cycles spent waiting; restarts every time ACCESS is entered.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == SETUP) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == ACCESS) && !sel_pready) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Fires on the edge that would bring the count to TIMEOUT; a PREADY on
  // that same edge takes priority and completes normally.
  assign tmo_hit = (state_reg == ACCESS) && !sel_pready &&
                   (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
`else
  // Without the watchdog ACCESS waits for PREADY indefinitely.
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a miss never leaves IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer && dec_hit) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (sel_pready || tmo_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; ready/err are single-cycle pulses.
  always_comb begin
    paddr_next   = paddr_reg;
    pwrite_next  = pwrite_reg;
    pwdata_next  = pwdata_reg;
    penable_next = penable_reg;
    psel_next    = psel_reg;
    rdata_next   = rdata_reg;
    ready_next   = 1'b0;
    err_next     = 1'b0;
    busy_next    = busy_reg;
    slv_idx_next = slv_idx_reg;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          paddr_next   = addr;
          pwrite_next  = write;
          pwdata_next  = wdata;
          slv_idx_next = dec_index;
          if (dec_hit) begin
            psel_next    = dec_sel;
            penable_next = 1'b0;
            busy_next    = 1'b1;
          end else begin
            ready_next = 1'b1;
            err_next   = 1'b1;
            rdata_next = '0;
            busy_next  = 1'b0;
          end
        end
      end
      SETUP: begin
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (sel_pready) begin
          psel_next    = '0;
          penable_next = 1'b0;
          ready_next   = 1'b1;
          busy_next    = 1'b0;
          if (!pwrite_reg) begin
            rdata_next = sel_prdata;
          end
        end else if (tmo_hit) begin
          psel_next    = '0;
          penable_next = 1'b0;
          ready_next   = 1'b1;
          err_next     = 1'b1;
          rdata_next   = '0;
          busy_next    = 1'b0;
        end
      end
      default: begin
        psel_next    = '0;
        penable_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      paddr_reg   <= '0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= '0;
      penable_reg <= 1'b0;
      psel_reg    <= '0;
      rdata_reg   <= '0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      slv_idx_reg <= '0;
    end else begin
      paddr_reg   <= paddr_next;
      pwrite_reg  <= pwrite_next;
      pwdata_reg  <= pwdata_next;
      penable_reg <= penable_next;
      psel_reg    <= psel_next;
      rdata_reg   <= rdata_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      slv_idx_reg <= slv_idx_next;
    end
  end

  assign PADDR   = paddr_reg;
  assign PWRITE  = pwrite_reg;
  assign PWDATA  = pwdata_reg;
  assign PENABLE = penable_reg;
  assign PSEL    = psel_reg;
  assign rdata   = rdata_reg;
  assign ready   = ready_reg;
  assign err     = err_reg;
  assign busy    = busy_reg;

endmodule
